mem_port_bridge: RTL and testbench
==================================

# mem_port_bridge

Per-CPU bridge between one slc3 core's active-low OE/WE memory strobes and one request port of the IOhandler2 SRAM arbiter. It posts CPU writes into a small write buffer, so the core completes a store without waiting for arbitration. It serves reads either by forwarding from the buffer or by a blocking arbiter read. It returns the core's memReady handshake as a single-cycle pulse. One instance sits upstream of each of the five arbiter ports.

## Interface
- DEPTH, 2: write-buffer entries (power of two, ≥2)
- ADDR_W, 16: address width
- DATA_W, 16: data width

- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- cpu_OE  in  1  active-low read strobe from core
- cpu_WE  in  1  active-low write strobe from core
- cpu_ADDR  in  ADDR_W  core address
- cpu_Data_to_SRAM  in  DATA_W  core write data
- memReady  out  1  one-cycle pulse: core operation complete
- Data_from_SRAM  out  DATA_W  read data to core; held until next read completes
- readRequest  out  1  active-high read request to arbiter
- writeRequest  out  1  active-high write request to arbiter
- ADDR  out  ADDR_W  address to arbiter
- DATA  out  DATA_W  write data to arbiter
- DataToCPUs  in  DATA_W  read data from arbiter; valid in the requestDone cycle
- requestDone  in  1  one-cycle completion pulse from arbiter
- wbuf_count  out  $clog2(DEPTH)+1  occupied buffer entries
- busy  out  1  high when buffer is non-empty, the arbiter FSM is not idle, or a core op is pending

## Operation
- Reset values: memReady=0, Data_from_SRAM=0, readRequest=0, writeRequest=0, ADDR=0, DATA=0, wbuf_count=0, busy=0, armed=1. The buffer is emptied, and buffered writes are discarded.
- Core handshake: the core holds a strobe low until memReady. An op is accepted only while armed=1. Acceptance clears armed. armed is set again at the first edge that samples both strobes high.
- If both strobes are low, the op is a write; the read is ignored.
- Write accept: taken when the strobe is sampled low, armed=1, and wbuf_count<DEPTH. {cpu_ADDR, cpu_Data_to_SRAM} is pushed at the tail. If the buffer is full, the op stalls with no memReady, and the push happens at the first edge where a slot is free, including the same edge as a pop.
- Read accept, forwarding hit: cpu_ADDR matches a buffered entry. Data_from_SRAM takes the youngest matching entry's data. No arbiter access is made.
- Read accept, miss: waits until the buffer is empty and the arbiter FSM is in A_IDLE. The bridge then enters A_READ with ADDR=cpu_ADDR.
- Reads never bypass buffered writes to other addresses; this preserves ordering across CPUs.
- Arbiter FSM states and transitions:
  - A_IDLE → A_WRITE when the buffer is non-empty and no read miss is ready. ADDR/DATA are loaded from the head entry, and writeRequest=1.
  - A_IDLE → A_READ on a read miss with the buffer empty. readRequest=1.
  - A_WRITE: on requestDone, pop the head, drop writeRequest, go to A_IDLE.
  - A_READ: on requestDone, latch DataToCPUs into Data_from_SRAM, drop readRequest, pulse memReady, go to A_IDLE.
- At most one of readRequest/writeRequest is high at a time.
- ADDR/DATA are constant while either request is high.
- requestDone sampled in A_IDLE is ignored.
- Simultaneous push and pop leaves wbuf_count unchanged. Pointers wrap modulo DEPTH.
- Reset asserted mid-operation (including while a request is high) returns all state to reset values at that edge. No memReady is generated for the aborted op.

## Timing
- Write, buffer not full: strobe sampled low at edge N → memReady=1 for exactly the cycle after N. The entry is counted in wbuf_count from the cycle after N.
- Write, buffer full: memReady follows the push edge by one cycle.
- The first arbiter write begins with writeRequest high in the cycle after the edge where the FSM leaves A_IDLE. That is at earliest the edge after the push, which is 2 cycles after the accept edge.
- Forwarding read: accepted at edge N → Data_from_SRAM valid and memReady=1 in the cycle after N.
- Read miss: readRequest rises in the cycle after the edge that takes A_IDLE→A_READ. requestDone sampled at edge M → Data_from_SRAM=DataToCPUs and memReady=1 in the cycle after M.
- memReady is never high for two consecutive cycles.

## Test plan
- Single write, idle arbiter: cpu_WE low with ADDR=0x0040, data=0x1234 → memReady pulse 1 cycle later; writeRequest with ADDR=0x0040, DATA=0x1234 until requestDone; wbuf_count then returns to 0.
- Buffer full stall, DEPTH=2, requestDone withheld: writes to 0x10, 0x11, 0x12 → first two get memReady; the third stalls until the first requestDone; memReady follows the push; wbuf_count stays 2.
- Forwarding: write 0x0050=0xAAAA then 0x0050=0xBBBB, arbiter stalled, then read 0x0050 → Data_from_SRAM=0xBBBB, memReady 1 cycle after accept, readRequest never asserted.
- Read miss ordering: buffered write to 0x0060, then read 0x0070 with DataToCPUs=0xC0DE → readRequest rises only after the write's requestDone; Data_from_SRAM=0xC0DE; memReady exactly one cycle.
- Re-arm: hold cpu_OE low for 10 cycles after memReady → exactly one read issued and one memReady pulse.
- Reset mid-read: assert Reset while readRequest=1 → next cycle readRequest=0, wbuf_count=0, memReady=0, Data_from_SRAM=0; a later requestDone is ignored.

Source files
------------

// File: rtl/mem_port_bridge.sv
// mem_port_bridge
//   Per-CPU bridge between one slc3 core's active-low OE/WE strobes and one
//   request port of the IOhandler2 SRAM arbiter. Core writes are posted into a
//   small FIFO write buffer so stores complete without waiting for arbitration.
//   Reads are forwarded from the buffer on an address hit, or otherwise issued
//   as a blocking arbiter read once all buffered writes have drained.
//
// Ports
//   Clk, Reset          : clock, synchronous active-high reset
//   cpu_OE / cpu_WE     : active-low read / write strobes from the core
//   cpu_ADDR            : core address
//   cpu_Data_to_SRAM    : core write data
//   memReady            : one-cycle completion pulse to the core
//   Data_from_SRAM      : read data to the core, held until the next read
//   readRequest         : read request to arbiter
//   writeRequest        : write request to arbiter
//   ADDR / DATA         : address / write data to arbiter
//   DataToCPUs          : read data from arbiter, valid with requestDone
//   requestDone         : one-cycle completion pulse from arbiter
//   wbuf_count          : occupied write-buffer entries
//   busy                : buffer non-empty, arbiter FSM active, or read pending
module mem_port_bridge #(
  parameter  int DEPTH  = 2,
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_OE,
  input  logic              cpu_WE,
  input  logic [ADDR_W-1:0] cpu_ADDR,
  input  logic [DATA_W-1:0] cpu_Data_to_SRAM,
  output logic              memReady,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              readRequest,
  output logic              writeRequest,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA,
  input  logic [DATA_W-1:0] DataToCPUs,
  input  logic              requestDone,
  output logic [CNT_W-1:0]  wbuf_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    A_IDLE,
    A_WRITE,
    A_READ
  } arb_state_t;

  arb_state_t        r_state;

  logic [ADDR_W-1:0] r_buf_addr [DEPTH];
  logic [DATA_W-1:0] r_buf_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              r_armed;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              r_memReady;
  logic [DATA_W-1:0] r_Data_from_SRAM;
  logic              r_readRequest;
  logic              r_writeRequest;
  logic [ADDR_W-1:0] r_ADDR;
  logic [DATA_W-1:0] r_DATA;

  logic              w_pop;
  logic              w_push;
  logic              w_rd_acc;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_miss_go;
  logic              w_strobes_high;

  assign w_strobes_high = cpu_OE && cpu_WE;
  assign w_pop          = (r_state == A_WRITE) && requestDone;
  // A full buffer still accepts when the head is popping on the same edge;
  // the freed slot is exactly the one the tail points at.
  assign w_push         = r_armed && !cpu_WE &&
                          ((r_count < CNT_W'(DEPTH)) || w_pop);
  // WE low wins over OE low: simultaneous strobes are treated as a write.
  assign w_rd_acc       = r_armed && !cpu_OE && cpu_WE;
  // With an empty buffer no hit is possible, so a fresh miss may launch the
  // arbiter read on its own accept edge.
  assign w_miss_go      = (r_state == A_IDLE) && (r_count == '0) &&
                          (r_rd_pend || (w_rd_acc && !w_hit));

  // Scan oldest to youngest so the last match is the youngest write.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_buf_addr[r_head + PTR_W'(i)] == cpu_ADDR)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_buf_data[r_head + PTR_W'(i)];
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by r_count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_buf_addr[r_tail] <= cpu_ADDR;
      r_buf_data[r_tail] <= cpu_Data_to_SRAM;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state          <= A_IDLE;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_armed          <= 1'b1;
      r_rd_pend        <= 1'b0;
      r_rd_addr        <= '0;
      r_memReady       <= 1'b0;
      r_Data_from_SRAM <= '0;
      r_readRequest    <= 1'b0;
      r_writeRequest   <= 1'b0;
      r_ADDR           <= '0;
      r_DATA           <= '0;
    end else begin
      r_memReady <= 1'b0;

      if (w_strobes_high) begin
        r_armed <= 1'b1;
      end

      if (w_push) begin
        r_tail     <= r_tail + 1'b1;
        r_armed    <= 1'b0;
        r_memReady <= 1'b1;
      end

      if (w_rd_acc) begin
        r_armed <= 1'b0;
        if (w_hit) begin
          r_Data_from_SRAM <= w_fwd_data;
          r_memReady       <= 1'b1;
        end else begin
          r_rd_pend <= 1'b1;
          r_rd_addr <= cpu_ADDR;
        end
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      case (r_state)
        A_IDLE: begin
          if (w_miss_go) begin
            r_state       <= A_READ;
            r_readRequest <= 1'b1;
            r_ADDR        <= r_rd_pend ? r_rd_addr : cpu_ADDR;
            r_rd_pend     <= 1'b0;
          end else if (r_count != '0) begin
            r_state        <= A_WRITE;
            r_writeRequest <= 1'b1;
            r_ADDR         <= r_buf_addr[r_head];
            r_DATA         <= r_buf_data[r_head];
          end
        end
        A_WRITE: begin
          if (requestDone) begin
            r_head         <= r_head + 1'b1;
            r_writeRequest <= 1'b0;
            r_state        <= A_IDLE;
          end
        end
        A_READ: begin
          if (requestDone) begin
            r_Data_from_SRAM <= DataToCPUs;
            r_readRequest    <= 1'b0;
            r_memReady       <= 1'b1;
            r_state          <= A_IDLE;
          end
        end
        default: begin
          r_state <= A_IDLE;
        end
      endcase
    end
  end

  assign memReady       = r_memReady;
  assign Data_from_SRAM = r_Data_from_SRAM;
  assign readRequest    = r_readRequest;
  assign writeRequest   = r_writeRequest;
  assign ADDR           = r_ADDR;
  assign DATA           = r_DATA;
  assign wbuf_count     = r_count;
  assign busy           = (r_count != '0) || (r_state != A_IDLE) || r_rd_pend;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed testbench for mem_port_bridge (DEPTH=2). The bench plays both the
// core (strobes) and the arbiter (requestDone/DataToCPUs). Inputs change 1 ns
// after a rising edge, and outputs are observed at that same point.
module tb_mem_port_bridge;

  logic        Clk;
  logic        Reset;
  logic        cpu_OE;
  logic        cpu_WE;
  logic [15:0] cpu_ADDR;
  logic [15:0] cpu_Data_to_SRAM;
  logic        memReady;
  logic [15:0] Data_from_SRAM;
  logic        readRequest;
  logic        writeRequest;
  logic [15:0] ADDR;
  logic [15:0] DATA;
  logic [15:0] DataToCPUs;
  logic        requestDone;
  logic [1:0]  wbuf_count;
  logic        busy;

  int n_tests;
  int n_fail;

  mem_port_bridge #(.DEPTH(2), .ADDR_W(16), .DATA_W(16)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .cpu_OE           (cpu_OE),
    .cpu_WE           (cpu_WE),
    .cpu_ADDR         (cpu_ADDR),
    .cpu_Data_to_SRAM (cpu_Data_to_SRAM),
    .memReady         (memReady),
    .Data_from_SRAM   (Data_from_SRAM),
    .readRequest      (readRequest),
    .writeRequest     (writeRequest),
    .ADDR             (ADDR),
    .DATA             (DATA),
    .DataToCPUs       (DataToCPUs),
    .requestDone      (requestDone),
    .wbuf_count       (wbuf_count),
    .busy             (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL reset_memReady got %0h exp 0", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'h0) begin n_fail++; $display("FAIL reset_data got %04h exp 0000", Data_from_SRAM); end
    n_tests++; if (readRequest !== 1'b0) begin n_fail++; $display("FAIL reset_readRequest got %0h exp 0", readRequest); end
    n_tests++; if (writeRequest !== 1'b0) begin n_fail++; $display("FAIL reset_writeRequest got %0h exp 0", writeRequest); end
    n_tests++; if (ADDR !== 16'h0) begin n_fail++; $display("FAIL reset_ADDR got %04h exp 0000", ADDR); end
    n_tests++; if (DATA !== 16'h0) begin n_fail++; $display("FAIL reset_DATA got %04h exp 0000", DATA); end
    n_tests++; if (wbuf_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", wbuf_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h exp 0", busy); end
  endtask

  task automatic test_single_write();
    cpu_WE = 1'b0; cpu_ADDR = 16'h0040; cpu_Data_to_SRAM = 16'h1234;
    tick();
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL sw_memReady got %0h exp 1", memReady); end
    n_tests++; if (wbuf_count !== 2'd1) begin n_fail++; $display("FAIL sw_count got %0d exp 1", wbuf_count); end
    n_tests++; if (writeRequest !== 1'b0) begin n_fail++; $display("FAIL sw_wr_early got %0h exp 0", writeRequest); end
    cpu_WE = 1'b1;
    tick();
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL sw_memReady_pulse got %0h exp 0", memReady); end
    n_tests++; if (writeRequest !== 1'b1) begin n_fail++; $display("FAIL sw_wr got %0h exp 1", writeRequest); end
    n_tests++; if (ADDR !== 16'h0040) begin n_fail++; $display("FAIL sw_ADDR got %04h exp 0040", ADDR); end
    n_tests++; if (DATA !== 16'h1234) begin n_fail++; $display("FAIL sw_DATA got %04h exp 1234", DATA); end
    tick();
    tick();
    n_tests++; if (writeRequest !== 1'b1) begin n_fail++; $display("FAIL sw_wr_hold got %0h exp 1", writeRequest); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    n_tests++; if (writeRequest !== 1'b0) begin n_fail++; $display("FAIL sw_wr_drop got %0h exp 0", writeRequest); end
    n_tests++; if (wbuf_count !== 2'd0) begin n_fail++; $display("FAIL sw_count_end got %0d exp 0", wbuf_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_end got %0h exp 0", busy); end
  endtask

  task automatic test_full_stall();
    cpu_WE = 1'b0; cpu_ADDR = 16'h0010; cpu_Data_to_SRAM = 16'h0A10;
    tick();
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL fs_ready0 got %0h exp 1", memReady); end
    cpu_WE = 1'b1;
    tick();
    cpu_WE = 1'b0; cpu_ADDR = 16'h0011; cpu_Data_to_SRAM = 16'h0A11;
    tick();
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL fs_ready1 got %0h exp 1", memReady); end
    n_tests++; if (wbuf_count !== 2'd2) begin n_fail++; $display("FAIL fs_count2 got %0d exp 2", wbuf_count); end
    cpu_WE = 1'b1;
    tick();
    cpu_WE = 1'b0; cpu_ADDR = 16'h0012; cpu_Data_to_SRAM = 16'h0A12;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL fs_stall_ready cyc %0d got %0h exp 0", i, memReady); end
      n_tests++; if (wbuf_count !== 2'd2) begin n_fail++; $display("FAIL fs_stall_count cyc %0d got %0d exp 2", i, wbuf_count); end
    end
    n_tests++; if (ADDR !== 16'h0010) begin n_fail++; $display("FAIL fs_head_addr got %04h exp 0010", ADDR); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL fs_push_ready got %0h exp 1", memReady); end
    n_tests++; if (wbuf_count !== 2'd2) begin n_fail++; $display("FAIL fs_push_count got %0d exp 2", wbuf_count); end
    cpu_WE = 1'b1;
    tick();
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL fs_push_pulse got %0h exp 0", memReady); end
    n_tests++; if (ADDR !== 16'h0011 || writeRequest !== 1'b1) begin n_fail++; $display("FAIL fs_second got %04h/%0h exp 0011/1", ADDR, writeRequest); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    tick();
    n_tests++; if (ADDR !== 16'h0012 || DATA !== 16'h0A12) begin n_fail++; $display("FAIL fs_third got %04h/%04h exp 0012/0a12", ADDR, DATA); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    n_tests++; if (wbuf_count !== 2'd0) begin n_fail++; $display("FAIL fs_drain got %0d exp 0", wbuf_count); end
  endtask

  task automatic test_forward();
    int rr_seen;
    rr_seen = 0;
    cpu_WE = 1'b0; cpu_ADDR = 16'h0050; cpu_Data_to_SRAM = 16'hAAAA;
    tick();
    cpu_WE = 1'b1;
    tick();
    cpu_WE = 1'b0; cpu_Data_to_SRAM = 16'hBBBB;
    tick();
    cpu_WE = 1'b1;
    tick();
    cpu_OE = 1'b0; cpu_ADDR = 16'h0050;
    tick();
    if (readRequest) rr_seen++;
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got %0h exp 1", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'hBBBB) begin n_fail++; $display("FAIL fwd_data got %04h exp bbbb", Data_from_SRAM); end
    cpu_OE = 1'b1;
    tick();
    if (readRequest) rr_seen++;
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL fwd_pulse got %0h exp 0", memReady); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    if (readRequest) rr_seen++;
    tick();
    if (readRequest) rr_seen++;
    n_tests++; if (DATA !== 16'hBBBB) begin n_fail++; $display("FAIL fwd_second_write got %04h exp bbbb", DATA); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    n_tests++; if (rr_seen !== 0) begin n_fail++; $display("FAIL fwd_no_read got %0d exp 0", rr_seen); end
    n_tests++; if (wbuf_count !== 2'd0) begin n_fail++; $display("FAIL fwd_drain got %0d exp 0", wbuf_count); end
  endtask

  task automatic test_read_miss();
    cpu_WE = 1'b0; cpu_ADDR = 16'h0060; cpu_Data_to_SRAM = 16'h6666;
    tick();
    cpu_WE = 1'b1;
    tick();
    cpu_OE = 1'b0; cpu_ADDR = 16'h0070; DataToCPUs = 16'hC0DE;
    tick();
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL rm_no_ready got %0h exp 0", memReady); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy got %0h exp 1", busy); end
    tick();
    tick();
    n_tests++; if (readRequest !== 1'b0) begin n_fail++; $display("FAIL rm_early_rr got %0h exp 0", readRequest); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0;
    n_tests++; if (readRequest !== 1'b0) begin n_fail++; $display("FAIL rm_rr_at_pop got %0h exp 0", readRequest); end
    tick();
    n_tests++; if (readRequest !== 1'b1 || writeRequest !== 1'b0) begin n_fail++; $display("FAIL rm_rr got %0h/%0h exp 1/0", readRequest, writeRequest); end
    n_tests++; if (ADDR !== 16'h0070) begin n_fail++; $display("FAIL rm_addr got %04h exp 0070", ADDR); end
    requestDone = 1'b1;
    tick();
    requestDone = 1'b0; DataToCPUs = 16'h0000;
    n_tests++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %0h exp 1", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'hC0DE) begin n_fail++; $display("FAIL rm_data got %04h exp c0de", Data_from_SRAM); end
    tick();
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL rm_pulse got %0h exp 0", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'hC0DE) begin n_fail++; $display("FAIL rm_data_hold got %04h exp c0de", Data_from_SRAM); end
    cpu_OE = 1'b1;
    tick();
  endtask

  task automatic test_rearm();
    int pulses;
    int rises;
    logic prev_rr;
    pulses = 0; rises = 0; prev_rr = readRequest;
    cpu_OE = 1'b0; cpu_ADDR = 16'h0080; DataToCPUs = 16'h8888;
    for (int i = 0; i < 14; i++) begin
      requestDone = readRequest;
      tick();
      if (memReady) pulses++;
      if (readRequest && !prev_rr) rises++;
      prev_rr = readRequest;
    end
    requestDone = 1'b0;
    cpu_OE = 1'b1;
    tick();
    n_tests++; if (rises !== 1) begin n_fail++; $display("FAIL rearm_reads got %0d exp 1", rises); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL rearm_pulses got %0d exp 1", pulses); end
    n_tests++; if (Data_from_SRAM !== 16'h8888) begin n_fail++; $display("FAIL rearm_data got %04h exp 8888", Data_from_SRAM); end
  endtask

  task automatic test_reset_mid_read();
    cpu_OE = 1'b0; cpu_ADDR = 16'h0090;
    tick();
    n_tests++; if (readRequest !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rr got %0h exp 1", readRequest); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; cpu_OE = 1'b1;
    n_tests++; if (readRequest !== 1'b0) begin n_fail++; $display("FAIL rst_rr got %0h exp 0", readRequest); end
    n_tests++; if (wbuf_count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", wbuf_count); end
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %0h exp 0", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'h0) begin n_fail++; $display("FAIL rst_data got %04h exp 0000", Data_from_SRAM); end
    requestDone = 1'b1; DataToCPUs = 16'hDEAD;
    tick();
    requestDone = 1'b0;
    n_tests++; if (memReady !== 1'b0) begin n_fail++; $display("FAIL rst_late_ready got %0h exp 0", memReady); end
    n_tests++; if (Data_from_SRAM !== 16'h0) begin n_fail++; $display("FAIL rst_late_data got %04h exp 0000", Data_from_SRAM); end
    tick();
    n_tests++; if (memReady !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle got %0h/%0h exp 0/0", memReady, busy); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    Reset = 1'b0; cpu_OE = 1'b1; cpu_WE = 1'b1;
    cpu_ADDR = '0; cpu_Data_to_SRAM = '0;
    DataToCPUs = '0; requestDone = 1'b0;
    tick();
    test_reset();
    test_single_write();
    test_full_stall();
    test_forward();
    test_read_miss();
    test_rearm();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
